asy_fifo_output: RTL and testbench

- Byte-wide receive FIFO on the SPI MISO return path.
- Bytes on wdata are pushed on each rising edge of the control_clk_miso strobe; all strobes are sampled in the single clk domain.
- A read_req pulse drains up to one 15-byte frame, packs it into the 120-bit data_out word, and frames the drain with an active-low spi_cs.

---
 rtl/asy_fifo_output.sv | 166 ++++++++++++++++
 tb/tb_asy_fifo_output.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/asy_fifo_output.sv
// rtl/asy_fifo_output.sv - MISO receive FIFO draining frames of FRAME_BYTES bytes into one wide word
// Strobes are synchronized into clk; a read request pops up to one frame while spi_cs is held low.
module asy_fifo_output #(
    parameter int MEMDEPTH    = 30,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_BYTES = 15
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic                              control_clk_miso,
    input  logic                              read_req,
    output logic [DATA_WIDTH*FRAME_BYTES-1:0] data_out,
    output logic                              spi_cs
);

    localparam int AW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int NW = $clog2(FRAME_BYTES + 1);
    localparam int FW = DATA_WIDTH * FRAME_BYTES;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            wr_sync_q, wr_sync_d;
    logic [2:0]            rd_sync_q, rd_sync_d;
    logic                  wr_pulse_q, wr_pulse_d;
    logic                  rd_pulse_q, rd_pulse_d;
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [NW-1:0]         n_q, n_d;
    logic [NW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shadow_q [FRAME_BYTES];
    logic [DATA_WIDTH-1:0] shadow_d [FRAME_BYTES];
    logic [FW-1:0]         data_out_q, data_out_d;
    logic                  spi_cs_q, spi_cs_d;
    logic [DATA_WIDTH-1:0] mem_q [MEMDEPTH];

    logic                  push;
    logic                  pop;
    logic [NW-1:0]         frame_n;
    logic [FW-1:0]         frame_packed;

    assign data_out = data_out_q;
    assign spi_cs   = spi_cs_q;

    // 2-FF synchronizer followed by a registered rising-edge detector on each strobe
    always_comb begin
        wr_sync_d  = {wr_sync_q[1:0], control_clk_miso};
        rd_sync_d  = {rd_sync_q[1:0], read_req};
        wr_pulse_d = wr_sync_q[1] & ~wr_sync_q[2];
        rd_pulse_d = rd_sync_q[1] & ~rd_sync_q[2];
    end

    always_comb begin
        if (count_q > CW'(FRAME_BYTES)) begin
            frame_n = NW'(FRAME_BYTES);
        end else begin
            frame_n = NW'(count_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        data_out_d   = data_out_q;
        spi_cs_d     = spi_cs_q;
        pop          = 1'b0;
        frame_packed = '0;

        case (state_q)
            IDLE: begin
                if (rd_pulse_q && (frame_n != '0)) begin
                    n_d      = frame_n;
                    idx_d    = '0;
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        shadow_d[i] = '0;
                    end
                    spi_cs_d = 1'b0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                pop             = 1'b1;
                shadow_d[idx_q] = mem_q[rptr_q];
                idx_d           = idx_q + NW'(1);
                if (idx_d == n_q) begin
                    // Oldest byte lands in the most significant position
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        frame_packed[(FRAME_BYTES-1-i)*DATA_WIDTH +: DATA_WIDTH] = shadow_d[i];
                    end
                    data_out_d = frame_packed;
                    spi_cs_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
    always_comb begin
        push    = wr_pulse_q && ((count_q < CW'(MEMDEPTH)) || pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = (wptr_q == AW'(MEMDEPTH - 1)) ? '0 : wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == AW'(MEMDEPTH - 1)) ? '0 : rptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_sync_q  <= '0;
            rd_sync_q  <= '0;
            wr_pulse_q <= 1'b0;
            rd_pulse_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            shadow_q   <= '{default: '0};
            data_out_q <= '0;
            spi_cs_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_sync_q  <= wr_sync_d;
            rd_sync_q  <= rd_sync_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            spi_cs_q   <= spi_cs_d;
        end
    end

endmodule

// File: tb/tb_asy_fifo_output.sv
// tb/tb_asy_fifo_output.sv - scoreboard bench for asy_fifo_output
module tb_asy_fifo_output;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   wdata = 8'h00;
    logic         control_clk_miso = 1'b0;
    logic         read_req = 1'b0;
    logic [119:0] data_out;
    logic         spi_cs;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   model_q [$];
    logic [119:0] exp_frame_q [$];
    int           exp_len_q [$];
    logic [119:0] last_frame = '0;

    always #5 clk = ~clk;

    asy_fifo_output dut (
        .clk              (clk),
        .rst              (rst),
        .wdata            (wdata),
        .control_clk_miso (control_clk_miso),
        .read_req         (read_req),
        .data_out         (data_out),
        .spi_cs           (spi_cs)
    );

    task automatic check(input string tag, input logic [119:0] got, input logic [119:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        wdata = b;
        @(negedge clk);
        control_clk_miso = 1'b1;
        repeat (6) @(negedge clk);
        control_clk_miso = 1'b0;
        repeat (4) @(negedge clk);
        if (model_q.size() < 30) model_q.push_back(b);
    endtask

    task automatic do_read(input string tag, input bit extra);
        int n;
        int cycles;
        int low;
        int stray;
        logic [119:0] frame;
        n = (model_q.size() > 15) ? 15 : model_q.size();
        frame = '0;
        for (int i = 0; i < 15; i++) begin
            frame = {frame[111:0], (i < n) ? model_q.pop_front() : 8'h00};
        end
        if (n > 0) begin
            exp_frame_q.push_back(frame);
            exp_len_q.push_back(n);
        end
        @(negedge clk);
        read_req = 1'b1;
        cycles = 0;
        while (spi_cs && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        read_req = 1'b0;
        if (n == 0) begin
            check({tag, "_empty_cs"}, {119'd0, spi_cs}, 120'd1);
            check({tag, "_empty_data"}, data_out, last_frame);
        end else begin
            check({tag, "_start"}, {119'd0, (cycles >= 3 && cycles <= 4)}, 120'd1);
            low = 0;
            while (!spi_cs && low < 40) begin
                @(negedge clk);
                low++;
                if (extra && low == 3) read_req = 1'b1;
                if (extra && low == 8) read_req = 1'b0;
            end
            check({tag, "_len"}, 120'(low), 120'(exp_len_q.pop_front()));
            last_frame = exp_frame_q.pop_front();
            check({tag, "_data"}, data_out, last_frame);
            if (extra) begin
                stray = 0;
                repeat (12) begin
                    @(negedge clk);
                    if (!spi_cs) stray++;
                end
                check({tag, "_ignored"}, 120'(stray), 120'd0);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int cycles;
        logic [7:0] full_vec [15];
        full_vec = '{8'd1, 8'd2, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
                     8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd55, 8'd200};

        repeat (5) @(negedge clk);
        check("reset_data", data_out, 120'd0);
        check("reset_cs", {119'd0, spi_cs}, 120'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_read("empty", 1'b0);

        for (int i = 0; i < 15; i++) push_byte(full_vec[i]);
        do_read("full", 1'b0);
        check("full_literal", data_out, 120'h01_02_14_1E_28_32_3C_46_64_78_82_8C_96_37_C8);
        do_read("after_full", 1'b0);

        push_byte(8'd1);
        push_byte(8'd2);
        push_byte(8'd20);
        do_read("partial", 1'b0);
        check("partial_literal", data_out, {24'h010214, 96'd0});

        for (int i = 0; i < 32; i++) push_byte(8'(i));
        do_read("ovf0", 1'b0);
        do_read("ovf1", 1'b0);
        do_read("ovf_empty", 1'b0);
        for (int i = 16; i < 20; i++) push_byte(8'(i));
        do_read("wrap", 1'b0);
        check("wrap_literal", data_out, {32'h10111213, 88'd0});

        for (int i = 0; i < 20; i++) push_byte(8'(8'd100 + 8'(i)));
        fork
            do_read("conc", 1'b1);
            begin
                repeat (5) @(negedge clk);
                push_byte(8'hA0);
                push_byte(8'hA1);
                push_byte(8'hA2);
            end
        join
        do_read("conc_rest", 1'b0);

        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + 8'(i)));
        @(negedge clk);
        read_req = 1'b1;
        cycles = 0;
        while (spi_cs && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        read_req = 1'b0;
        check("mid_started", {119'd0, spi_cs}, 120'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cs", {119'd0, spi_cs}, 120'd1);
        check("mid_rst_data", data_out, 120'd0);
        rst = 1'b0;
        model_q.delete();
        last_frame = '0;
        repeat (2) @(negedge clk);
        do_read("mid_empty", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
